// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: bus widths, trap cause codes, CSR addresses and mstatus rewrite helpers.
package trap_ctrl_pkg;
  localparam int RegBus = 32;
  localparam int CsrAddrBus = 12;
  localparam logic [RegBus-1:0] TRAP_CAUSE_ILLEGAL = 32'd2;
  localparam logic [RegBus-1:0] TRAP_CAUSE_ECALL = 32'd11;
  localparam logic [RegBus-1:0] TRAP_CAUSE_EBREAK = 32'd3;
  localparam logic [RegBus-1:0] TRAP_CAUSE_EXT_INT = 32'h8000000B;
  localparam logic [RegBus-1:0] TRAP_CAUSE_SOFT_INT = 32'h80000003;
  localparam logic [RegBus-1:0] TRAP_CAUSE_TIMER_INT = 32'h80000007;
  localparam logic [CsrAddrBus-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CsrAddrBus-1:0] CSR_MTVEC = 12'h305;
  localparam logic [CsrAddrBus-1:0] CSR_MEPC = 12'h341;
  localparam logic [CsrAddrBus-1:0] CSR_MCAUSE = 12'h342;
  localparam logic [CsrAddrBus-1:0] CSR_MTVAL = 12'h343;
  // Entry: MPIE <= MIE, MIE <= 0
  function automatic logic [RegBus-1:0] entry_status(input logic [RegBus-1:0] s);
    return {s[31:8], s[3], s[6:4], 1'b0, s[2:0]};
  endfunction
  // mret: MIE <= MPIE, MPIE <= 1
  function automatic logic [RegBus-1:0] mret_status(input logic [RegBus-1:0] s);
    return {s[31:8], 1'b1, s[6:4], s[7], s[2:0]};
  endfunction
endpackage

// File: rtl/trap_cause_enc.sv
// trap_cause_enc: priority encoder of exceptions, mret and enabled interrupts.
module trap_cause_enc
  import trap_ctrl_pkg::*;
(
  input  logic              illegal_i,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              mret_i,
  input  logic              ext_i,
  input  logic              soft_i,
  input  logic              tcmp_i,
  input  logic              mie_i,
  input  logic              inst_valid_i,
  output logic              valid_o,
  output logic              is_int_o,
  output logic              is_mret_o,
  output logic [RegBus-1:0] cause_o
);
  logic exc, irq;
  assign exc = illegal_i | ecall_i | ebreak_i;
  assign irq = mie_i & inst_valid_i & (ext_i | soft_i | tcmp_i);
  assign valid_o = exc | mret_i | irq;
  assign is_mret_o = mret_i & ~exc;
  assign is_int_o = irq & ~exc & ~mret_i;
  always_comb begin
    cause_o = illegal_i ? TRAP_CAUSE_ILLEGAL :
              ecall_i   ? TRAP_CAUSE_ECALL :
              ebreak_i  ? TRAP_CAUSE_EBREAK :
              ext_i     ? TRAP_CAUSE_EXT_INT :
              soft_i    ? TRAP_CAUSE_SOFT_INT :
              tcmp_i    ? TRAP_CAUSE_TIMER_INT : '0;
  end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap entry / mret sequencer on the CSR trap channel, holding the pipeline throughout.
// TRAP_VECTORED_EN: interrupts redirect to mtvec base + 4*code instead of base.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_trap_valid_i,
  input  logic                  tcmp_trap_valid_i,
  input  logic                  soft_trap_valid_i,
  input  logic                  mstatus_MIE3_i,
  input  logic                  inst_valid_i,
  input  logic                  ecall_i,
  input  logic                  ebreak_i,
  input  logic                  illegal_i,
  input  logic                  mret_i,
  input  logic [RegBus-1:0]     pc_i,
  input  logic [RegBus-1:0]     next_pc_i,
  input  logic [RegBus-1:0]     inst_i,
  input  logic [RegBus-1:0]     mepc_i,
  output logic                  trap_csr_we_o,
  output logic [CsrAddrBus-1:0] trap_csr_addr_o,
  output logic [RegBus-1:0]     trap_csr_wdata_o,
  input  logic [RegBus-1:0]     trap_csr_rdata_i,
  output logic                  hold_o,
  output logic                  jump_flag_o,
  output logic [RegBus-1:0]     jump_addr_o
);
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, JUMP} state_t;
  state_t state_q, state_d;
  logic det_valid, det_int, det_mret, det_go, is_mret_q, we_d;
  logic [RegBus-1:0] det_cause, cause_q, epc_q, tval_q, mepc_q, entry_addr;
  logic [CsrAddrBus-1:0] addr_d;
  trap_cause_enc u_enc (
    .illegal_i   (illegal_i),
    .ecall_i     (ecall_i),
    .ebreak_i    (ebreak_i),
    .mret_i      (mret_i),
    .ext_i       (ex_trap_valid_i),
    .soft_i      (soft_trap_valid_i),
    .tcmp_i      (tcmp_trap_valid_i),
    .mie_i       (mstatus_MIE3_i),
    .inst_valid_i(inst_valid_i),
    .valid_o     (det_valid),
    .is_int_o    (det_int),
    .is_mret_o   (det_mret),
    .cause_o     (det_cause)
  );
  assign det_go = (state_q == IDLE) & det_valid;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = det_valid ? (det_mret ? R_STATUS : W_EPC) : IDLE;
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = W_TVAL;
      W_TVAL:   state_d = W_STATUS;
      W_STATUS: state_d = JUMP;
      R_STATUS: state_d = JUMP;
      default:  state_d = IDLE;
    endcase
  end
  // we/addr are registered off the next state so they are glitch-free in each step
  always_comb begin
    we_d = state_d inside {W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS};
    addr_d = (state_d == W_EPC)   ? CSR_MEPC :
             (state_d == W_CAUSE) ? CSR_MCAUSE :
             (state_d == W_TVAL)  ? CSR_MTVAL :
             (state_d == W_STATUS || state_d == R_STATUS) ? CSR_MSTATUS :
             (state_d == JUMP)    ? CSR_MTVEC : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      trap_csr_we_o <= 1'b0;
      trap_csr_addr_o <= '0;
      cause_q <= '0;
      epc_q <= '0;
      tval_q <= '0;
      mepc_q <= '0;
      is_mret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_csr_we_o <= we_d;
      trap_csr_addr_o <= addr_d;
      if (det_go) begin
        cause_q <= det_cause;
        epc_q <= det_int ? next_pc_i : pc_i;
        tval_q <= (illegal_i && !det_int) ? inst_i : '0;
        mepc_q <= mepc_i;
        is_mret_q <= det_mret;
      end
    end
  end
`ifdef TRAP_VECTORED_EN
  logic is_int_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) is_int_q <= 1'b0;
    else if (det_go) is_int_q <= det_int;
  end
  assign entry_addr = {trap_csr_rdata_i[31:2], 2'b00} + (is_int_q ? {25'd0, cause_q[4:0], 2'b00} : '0);
`else
  assign entry_addr = {trap_csr_rdata_i[31:2], 2'b00};
`endif
  // status rewrite uses the asynchronous read of mstatus in the same cycle
  always_comb begin
    trap_csr_wdata_o = (state_q == W_EPC)    ? epc_q :
                       (state_q == W_CAUSE)  ? cause_q :
                       (state_q == W_TVAL)   ? tval_q :
                       (state_q == W_STATUS) ? entry_status(trap_csr_rdata_i) :
                       (state_q == R_STATUS) ? mret_status(trap_csr_rdata_i) : '0;
  end
  assign hold_o = rst_n & ((state_q != IDLE) | det_valid);
  assign jump_flag_o = state_q == JUMP;
  assign jump_addr_o = (state_q == JUMP) ? (is_mret_q ? mepc_q : entry_addr) : '0;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed trap scenarios checked cycle by cycle against a behavioural trap model.
module tb_trap_ctrl;
  typedef struct packed {
    logic        h;
    logic        we;
    logic [11:0] a;
    logic [31:0] wd;
    logic        jf;
    logic [31:0] ja;
  } rec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ext = 0, tmr = 0, sft = 0, mie = 0, iv = 0, ec = 0, eb = 0, il = 0, mr = 0;
  logic [31:0] pc = 0, npc = 0, inst = 0;
  logic we, hold, jf;
  logic [11:0] addr;
  logic [31:0] wdata, rdata, ja;
  logic [31:0] csr_mstatus = 32'h1888, csr_mtvec = 32'h201, csr_mepc = 0, csr_mcause = 0, csr_mtval = 0;
  logic poke_v = 0;
  logic [11:0] poke_a = 0;
  logic [31:0] poke_d = 0, last_ja = 0;
  int wr_cnt = 0, checks = 0, failures = 0;
  bit chk_en = 0;
  rec_t q[$];
  always #5 clk = ~clk;
  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_trap_valid_i(ext), .tcmp_trap_valid_i(tmr), .soft_trap_valid_i(sft),
    .mstatus_MIE3_i(mie), .inst_valid_i(iv), .ecall_i(ec), .ebreak_i(eb), .illegal_i(il), .mret_i(mr),
    .pc_i(pc), .next_pc_i(npc), .inst_i(inst), .mepc_i(csr_mepc), .trap_csr_we_o(we),
    .trap_csr_addr_o(addr), .trap_csr_wdata_o(wdata), .trap_csr_rdata_i(rdata), .hold_o(hold),
    .jump_flag_o(jf), .jump_addr_o(ja)
  );
  always_comb begin
    case (addr)
      12'h300: rdata = csr_mstatus;
      12'h305: rdata = csr_mtvec;
      12'h341: rdata = csr_mepc;
      12'h342: rdata = csr_mcause;
      12'h343: rdata = csr_mtval;
      default: rdata = 32'h0;
    endcase
  end
  always @(posedge clk) begin
    if (poke_v) begin
      if (poke_a == 12'h300) csr_mstatus <= poke_d;
      if (poke_a == 12'h341) csr_mepc <= poke_d;
    end else if (we) begin
      wr_cnt <= wr_cnt + 1;
      case (addr)
        12'h300: csr_mstatus <= wdata;
        12'h305: csr_mtvec <= wdata;
        12'h341: csr_mepc <= wdata;
        12'h342: csr_mcause <= wdata;
        12'h343: csr_mtval <= wdata;
        default: ;
      endcase
    end
  end
  function automatic void chk(string n, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      rec_t e;
      e = q.size() != 0 ? q.pop_front() : '0;
      chk("cycle", {hold, we, addr, wdata, jf, ja}, e);
      if (jf) last_ja <= ja;
    end
  end
  function automatic rec_t r(logic h, logic w, logic [11:0] a, logic [31:0] d, logic j, logic [31:0] t);
    r = '{h, w, a, d, j, t};
  endfunction
  // Model: decide the trap from the priority rules and list every cycle's expected outputs.
  task automatic trap(input logic i_il, i_ec, i_eb, i_mr, i_ext, i_sft, i_tmr, i_mie, i_iv,
                      input logic [31:0] i_pc, i_npc, i_inst);
    logic [31:0] cause, epc, tval, tgt;
    bit irq_ok, exc, isint;
    @(posedge clk); #1;
    {il, ec, eb, mr, ext, sft, tmr, mie, iv} = {i_il, i_ec, i_eb, i_mr, i_ext, i_sft, i_tmr, i_mie, i_iv};
    {pc, npc, inst} = {i_pc, i_npc, i_inst};
    irq_ok = i_mie && i_iv && (i_ext || i_sft || i_tmr);
    exc = i_il || i_ec || i_eb;
    isint = !exc && !i_mr && irq_ok;
    if (exc || isint) begin
      cause = i_il ? 2 : i_ec ? 11 : i_eb ? 3 : i_ext ? 32'h8000000B : i_sft ? 32'h80000003 : 32'h80000007;
      epc = isint ? i_npc : i_pc;
      tval = i_il ? i_inst : 0;
      tgt = csr_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
      if (isint) tgt = tgt + (cause & 32'h1F) * 4;
`endif
      q.push_back(r(1, 0, 0, 0, 0, 0));
      q.push_back(r(1, 1, 12'h341, epc, 0, 0));
      q.push_back(r(1, 1, 12'h342, cause, 0, 0));
      q.push_back(r(1, 1, 12'h343, tval, 0, 0));
      q.push_back(r(1, 1, 12'h300, (csr_mstatus & ~32'h88) | (csr_mstatus[3] ? 32'h80 : 0), 0, 0));
      q.push_back(r(1, 0, 12'h305, 0, 1, tgt));
    end else if (i_mr) begin
      q.push_back(r(1, 0, 0, 0, 0, 0));
      q.push_back(r(1, 1, 12'h300, (csr_mstatus & ~32'h08) | 32'h80 | (csr_mstatus[7] ? 32'h8 : 0), 0, 0));
      q.push_back(r(1, 0, 12'h305, 0, 1, csr_mepc));
    end
    @(posedge clk); #1;
    {il, ec, eb, mr, ext, sft, tmr, mie, iv} = '0;
    for (int i = 0; i < 12 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected cycles left, required 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask
  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    {poke_v, poke_a, poke_d} = {1'b1, a, d};
    @(posedge clk); #1;
    poke_v = 0;
  endtask
  initial begin
    int w0;
    #12;
    chk("reset_outs", {hold, we, addr, wdata, jf, ja}, 0);
    rst_n = 1;
    chk_en = 1;
    trap(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h100, 32'h104, 32'hFFFFFFFF);
    chk("ill_mepc", csr_mepc, 32'h100);
    chk("ill_mcause", csr_mcause, 2);
    chk("ill_mtval", csr_mtval, 32'hFFFFFFFF);
    chk("ill_mstatus", csr_mstatus, 32'h1880);
    chk("ill_jump", last_ja, 32'h200);
    trap(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h40, 32'h44, 0);
    chk("tmr_mepc", csr_mepc, 32'h44);
    chk("tmr_mcause", csr_mcause, 32'h80000007);
    chk("tmr_mtval", csr_mtval, 0);
`ifdef TRAP_VECTORED_EN
    chk("tmr_jump", last_ja, 32'h21C);
`else
    chk("tmr_jump", last_ja, 32'h200);
`endif
    trap(0, 0, 0, 0, 1, 1, 0, 1, 1, 32'h80, 32'h84, 0);
    chk("extsoft_mcause", csr_mcause, 32'h8000000B);
    w0 = wr_cnt;
    trap(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h90, 32'h94, 0);
    trap(0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h90, 32'h94, 0);
    chk("masked_no_write", wr_cnt, w0);
    poke(12'h300, 32'h1880);
    poke(12'h341, 32'h44);
    trap(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h500, 32'h504, 0);
    chk("mret_mstatus", csr_mstatus, 32'h1888);
    chk("mret_jump", last_ja, 32'h44);
    trap(0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h600, 32'h604, 0);
    chk("ebreak_wins", csr_mcause, 3);
    chk("ebreak_mepc", csr_mepc, 32'h600);
    poke(12'h341, 32'h700);
    trap(0, 0, 0, 1, 0, 0, 1, 1, 1, 32'h20, 32'h24, 0);
    chk("mret_wins", last_ja, 32'h700);
    chk("mret_wins_cause", csr_mcause, 3);
    chk_en = 0;
    @(posedge clk); #1;
    {ec, mie, iv, pc, npc} = {3'b111, 32'h300, 32'h304};
    @(posedge clk); #1;
    {ec, mie, iv} = 0;
    @(posedge clk); #1;
    w0 = wr_cnt;
    rst_n = 0;
    #1;
    chk("rst_mid_outs", {hold, we, addr, wdata, jf, ja}, 0);
    chk("rst_mid_state", dut.state_q, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_nowrite", wr_cnt, w0);
    chk("rst_mid_mcause", csr_mcause, 3);
    rst_n = 1;
    chk_en = 1;
    trap(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h900, 32'h904, 0);
    chk("ecall_mcause", csr_mcause, 11);
    chk("ecall_mepc", csr_mepc, 32'h900);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, required completion");
    $fatal(1);
  end
endmodule
